hwag_div_sched: RTL and testbench

- Per-tooth scheduler that shares one sequential restoring divider among CH angle-delta requesters (ignition charge time, injection time, ...).
- Each divides a time quantity by the sub-tooth step period (scnt_top+1) to yield an angle delta.
- Triggered by the tooth edge (vr_edge_0). Snapshots all operands, serialises divisions in ascending channel order, double-buffers the results.
- Results become visible atomically on the next tooth edge.
- Replaces the per-requester integer_division instances in hwag.

---
 rtl/hwag_pkg.sv | 20 ++
 rtl/hwag_div_sched_if.sv | 26 ++
 rtl/div_restoring_seq.sv | 65 ++++++
 rtl/hwag_div_sched.sv | 153 +++++++++++++++
 tb/tb_hwag_div_sched.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/hwag_pkg.sv
// Shared types and constants for the hwag angle-delta divider scheduler.
package hwag_pkg;

  localparam int WIDTH_DEF = 24;
  localparam int CH_DEF    = 4;

  localparam int CH_IGN   = 0;
  localparam int CH_INJ   = 1;
  localparam int CH_DWELL = 2;
  localparam int CH_AUX   = 3;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    DIV,
    STORE,
    DONE
  } sched_state_e;

endpackage

// File: rtl/hwag_div_sched_if.sv
// Request/result bundle between the tooth-edge logic and the divider scheduler.
interface hwag_div_sched_if #(
  parameter int WIDTH = 24,
  parameter int CH    = 4
) ();
  logic                  start;
  logic [WIDTH-1:0]      divisor;
  logic [CH*WIDTH-1:0]   dividend;
  logic [CH-1:0]         ch_ena;
  logic [CH*WIDTH-1:0]   result;
  logic [CH-1:0]         valid;
  logic [CH-1:0]         dz;
  logic                  busy;
  logic                  done;
  logic                  ovr;

  modport master (
    output start, divisor, dividend, ch_ena,
    input  result, valid, dz, busy, done, ovr
  );

  modport slave (
    input  start, divisor, dividend, ch_ena,
    output result, valid, dz, busy, done, ovr
  );
endinterface

// File: rtl/div_restoring_seq.sv
// Sequential restoring divider: one quotient bit per cycle, MSB first, WIDTH cycles per divide.
module div_restoring_seq #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             last
);
  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             run_q, run_d;
  logic [WIDTH:0]   partial;

  // A zero divisor always passes the compare, so the quotient saturates to all ones.
  always_comb begin
    quot_d  = quot_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    run_d   = run_q;
    partial = {rem_q, quot_q[WIDTH-1]};
    if (load) begin
      quot_d = dividend;
      rem_d  = '0;
      cnt_d  = CW'(WIDTH - 1);
      run_d  = 1'b1;
    end else if (run_q) begin
      if (partial >= {1'b0, divisor}) begin
        rem_d  = partial[WIDTH-1:0] - divisor;
        quot_d = {quot_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_d  = partial[WIDTH-1:0];
        quot_d = {quot_q[WIDTH-2:0], 1'b0};
      end
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == '0) run_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      quot_q <= '0;
      rem_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
    end else begin
      quot_q <= quot_d;
      rem_q  <= rem_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
    end
  end

  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign last      = run_q && (cnt_q == '0);

endmodule

// File: rtl/hwag_div_sched.sv
// Per-tooth scheduler sharing one restoring divider across CH requesters, with
// double-buffered results committed atomically on the next tooth edge.
module hwag_div_sched
  import hwag_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CH    = CH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  hwag_div_sched_if.slave   bus
);
  localparam int IW = (CH > 1) ? $clog2(CH) : 1;

  sched_state_e        state_q, state_d;
  logic [WIDTH-1:0]    divisor_q, divisor_d;
  logic [CH*WIDTH-1:0] dividend_q, dividend_d;
  logic [CH-1:0]       ena_q, ena_d;
  logic [CH-1:0]       pending_q, pending_d;
  logic [IW-1:0]       cur_q, cur_d;
  logic [CH*WIDTH-1:0] shadow_q, shadow_d;
  logic [CH-1:0]       shadow_dz_q, shadow_dz_d;
  logic                complete_q, complete_d;
  logic [CH*WIDTH-1:0] result_q, result_d;
  logic [CH-1:0]       valid_q, valid_d;
  logic [CH-1:0]       dz_q, dz_d;

  logic [IW-1:0]       pick;
  logic                div_load;
  logic [WIDTH-1:0]    div_quot;
  logic [WIDTH-1:0]    div_rem;
  logic                div_last;

  always_comb begin
    pick = '0;
    for (int i = CH - 1; i >= 0; i--) begin
      if (pending_q[i]) pick = IW'(i);
    end
  end

  div_restoring_seq #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .rst       (rst),
    .load      (div_load),
    .dividend  (dividend_q[int'(pick)*WIDTH +: WIDTH]),
    .divisor   (divisor_q),
    .quotient  (div_quot),
    .remainder (div_rem),
    .last      (div_last)
  );

  // A start overrides whatever the pass was doing; a pass finishing this very
  // cycle (DONE) still counts as complete and is committed.
  always_comb begin
    state_d     = state_q;
    divisor_d   = divisor_q;
    dividend_d  = dividend_q;
    ena_d       = ena_q;
    pending_d   = pending_q;
    cur_d       = cur_q;
    shadow_d    = shadow_q;
    shadow_dz_d = shadow_dz_q;
    complete_d  = complete_q;
    result_d    = result_q;
    valid_d     = valid_q;
    dz_d        = dz_q;
    div_load    = 1'b0;
    bus.done    = 1'b0;
    bus.ovr     = 1'b0;

    case (state_q)
      SCAN: begin
        if (pending_q == '0) begin
          state_d = DONE;
        end else begin
          cur_d    = pick;
          div_load = 1'b1;
          state_d  = DIV;
        end
      end
      DIV: begin
        if (div_last) state_d = STORE;
      end
      STORE: begin
        shadow_d[int'(cur_q)*WIDTH +: WIDTH] = div_quot;
        shadow_dz_d[cur_q] = (divisor_q == '0);
        pending_d[cur_q]   = 1'b0;
        state_d            = SCAN;
      end
      DONE: begin
        bus.done   = 1'b1;
        complete_d = 1'b1;
        state_d    = IDLE;
      end
      default: ;
    endcase

    if (bus.start) begin
      bus.ovr = (state_q == SCAN) || (state_q == DIV) || (state_q == STORE);
      if (complete_q || (state_q == DONE)) begin
        for (int i = 0; i < CH; i++) begin
          if (ena_q[i]) begin
            result_d[i*WIDTH +: WIDTH] = shadow_q[i*WIDTH +: WIDTH];
            dz_d[i] = shadow_dz_q[i];
          end
        end
        valid_d    = ena_q;
        complete_d = 1'b0;
      end
      divisor_d  = bus.divisor;
      dividend_d = bus.dividend;
      ena_d      = bus.ch_ena;
      pending_d  = bus.ch_ena;
      state_d    = SCAN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      divisor_q   <= '0;
      dividend_q  <= '0;
      ena_q       <= '0;
      pending_q   <= '0;
      cur_q       <= '0;
      shadow_q    <= '0;
      shadow_dz_q <= '0;
      complete_q  <= 1'b0;
      result_q    <= '0;
      valid_q     <= '0;
      dz_q        <= '0;
    end else begin
      state_q     <= state_d;
      divisor_q   <= divisor_d;
      dividend_q  <= dividend_d;
      ena_q       <= ena_d;
      pending_q   <= pending_d;
      cur_q       <= cur_d;
      shadow_q    <= shadow_d;
      shadow_dz_q <= shadow_dz_d;
      complete_q  <= complete_d;
      result_q    <= result_d;
      valid_q     <= valid_d;
      dz_q        <= dz_d;
    end
  end

  assign bus.result = result_q;
  assign bus.valid  = valid_q;
  assign bus.dz     = dz_q;
  assign bus.busy   = (state_q != IDLE);

endmodule

// File: tb/tb_hwag_div_sched.sv
// Scoreboard bench for hwag_div_sched: directed passes with hand-computed quotients and cycle timing.
module tb_hwag_div_sched;
  localparam int W = 24;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  hwag_div_sched_if #(.WIDTH(W), .CH(N)) bus ();

  hwag_div_sched #(.WIDTH(W), .CH(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int           at;
    logic [95:0]  res;
    logic [3:0]   val;
    logic [3:0]   dz;
  } exp_out_t;

  int       cyc = 0;
  int       n_cmp = 0;
  int       n_fail = 0;
  int       exp_done[$];
  int       exp_ovr[$];
  exp_out_t exp_out[$];
  int       e_done;
  int       e_ovr;
  exp_out_t e_out;
  int       t;
  int       t2;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [95:0] pk(input logic [23:0] r0, r1, r2, r3);
    return {r3, r2, r1, r0};
  endfunction

  task automatic checkOutput(input string name, input logic [95:0] act, input logic [95:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [3:0] ena, input logic [23:0] dv, input logic [95:0] dvd);
    bus.ch_ena   = ena;
    bus.divisor  = dv;
    bus.dividend = dvd;
    bus.start    = 1'b1;
    waitCycles(1);
    bus.start    = 1'b0;
  endtask

  task automatic expectOut(input int at, input logic [95:0] res, input logic [3:0] val, input logic [3:0] dz);
    exp_out_t o;
    o.at  = at;
    o.res = res;
    o.val = val;
    o.dz  = dz;
    exp_out.push_back(o);
  endtask

  // Monitor: every done/ovr pulse must match the next expected cycle; committed outputs checked on schedule.
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      e_done = (exp_done.size() > 0) ? exp_done.pop_front() : -1;
      checkOutput("done_cycle", cyc, e_done);
    end
    if (bus.ovr === 1'b1) begin
      e_ovr = (exp_ovr.size() > 0) ? exp_ovr.pop_front() : -1;
      checkOutput("ovr_cycle", cyc, e_ovr);
    end
    if (exp_out.size() > 0 && exp_out[0].at == cyc) begin
      e_out = exp_out.pop_front();
      checkOutput("result", bus.result, e_out.res);
      checkOutput("valid", bus.valid, e_out.val);
      checkOutput("dz", bus.dz, e_out.dz);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.ch_ena   = '0;
    bus.divisor  = '0;
    bus.dividend = '0;
    waitCycles(3);
    checkOutput("rst_result", bus.result, 0);
    checkOutput("rst_valid", bus.valid, 0);
    checkOutput("rst_dz", bus.dz, 0);
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_done", bus.done, 0);
    checkOutput("rst_ovr", bus.ovr, 0);
    rst = 1'b0;
    waitCycles(1);

    $display("[TB] reset mid-DIV");
    applyStimulus(4'b1111, 24'd7, pk(100, 7, 6, 24'hFFFFFF));
    waitCycles(9);
    checkOutput("mid_div_busy", bus.busy, 1);
    rst = 1'b1;
    waitCycles(3);
    rst = 1'b0;
    checkOutput("midrst_busy", bus.busy, 0);
    checkOutput("midrst_result", bus.result, 0);
    checkOutput("midrst_valid", bus.valid, 0);
    checkOutput("midrst_dz", bus.dz, 0);
    waitCycles(1);
    checkOutput("postrst_busy", bus.busy, 0);

    $display("[TB] single channel 500000/1000");
    t = cyc;
    expectOut(t + 1, 0, 4'b0000, 4'b0000);
    exp_done.push_back(t + 28);
    applyStimulus(4'b0001, 24'd1000, pk(500000, 0, 0, 0));
    checkOutput("pass_busy", bus.busy, 1);
    waitCycles(29);

    $display("[TB] four channels by 7");
    t = cyc;
    expectOut(t + 1, pk(500, 0, 0, 0), 4'b0001, 4'b0000);
    exp_done.push_back(t + 106);
    applyStimulus(4'b1111, 24'd7, pk(100, 7, 6, 24'hFFFFFF));
    waitCycles(107);

    $display("[TB] divide by zero on channels 0 and 2");
    t = cyc;
    expectOut(t + 1, pk(14, 1, 0, 2396745), 4'b1111, 4'b0000);
    exp_done.push_back(t + 54);
    applyStimulus(4'b0101, 24'd0, pk(123, 77, 999, 88));
    waitCycles(55);

    $display("[TB] overrun restart at t+10");
    t = cyc;
    expectOut(t + 1, pk(24'hFFFFFF, 1, 24'hFFFFFF, 2396745), 4'b0101, 4'b0101);
    applyStimulus(4'b1111, 24'd3, pk(30, 31, 32, 300));
    waitCycles(9);
    t2 = cyc;
    exp_ovr.push_back(t2);
    expectOut(t2 + 1, pk(24'hFFFFFF, 1, 24'hFFFFFF, 2396745), 4'b0101, 4'b0101);
    exp_done.push_back(t2 + 106);
    applyStimulus(4'b1111, 24'd5, pk(50, 55, 60, 65));
    waitCycles(107);

    $display("[TB] start on done cycle, inputs changed mid-pass");
    t = cyc;
    expectOut(t + 1, pk(10, 11, 12, 13), 4'b1111, 4'b0000);
    exp_done.push_back(t + 54);
    applyStimulus(4'b0011, 24'd10, pk(1000, 2000, 0, 0));
    waitCycles(4);
    bus.dividend = pk(1, 2, 3, 4);
    bus.divisor  = 24'd1;
    waitCycles(49);
    t2 = cyc;
    expectOut(t2 + 1, pk(100, 200, 12, 13), 4'b0011, 4'b0000);
    exp_done.push_back(t2 + 28);
    applyStimulus(4'b1000, 24'd4, pk(7, 7, 7, 40));
    waitCycles(29);

    $display("[TB] empty pass");
    t = cyc;
    expectOut(t + 1, pk(100, 200, 12, 10), 4'b1000, 4'b0000);
    exp_done.push_back(t + 2);
    applyStimulus(4'b0000, 24'd1, 0);
    waitCycles(5);
    checkOutput("final_busy", bus.busy, 0);

    checkOutput("pending_done_events", exp_done.size(), 0);
    checkOutput("pending_ovr_events", exp_ovr.size(), 0);
    checkOutput("pending_output_checks", exp_out.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
